// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame path: controller states, NACK codes,
// framing constants and the CRC-8 (poly 0x07) helper.
package uart_frame_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DISPATCH = 3'd1;
  localparam logic [2:0] S_WAIT_RSP = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = S_IDLE,
    ST_DISPATCH = S_DISPATCH,
    ST_WAIT_RSP = S_WAIT_RSP,
    ST_SEND     = S_SEND,
    ST_RELEASE  = S_RELEASE
  } state_t;

  localparam logic [7:0] NACK_CRC      = 8'h01;
  localparam logic [7:0] NACK_TYPE_UNK = 8'h02;
  localparam logic [7:0] NACK_TIMEOUT  = 8'h03;
  localparam logic [7:0] RSP_TYPE_BIT  = 8'h80;
  localparam logic [7:0] SOF           = 8'hA5;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// Frame/handler bus of uart_frame_ctrl; master is the controller, slave is the
// RX/TX frame blocks plus the handlers.
interface uart_frame_ctrl_if #(
  parameter int unsigned NUM_HANDLERS = 4,
  parameter int unsigned MAX_PAYLOAD  = 255
);
  logic                                        rx_frame_valid;
  logic                                        rx_frame_ready;
  logic [7:0]                                  rx_frame_len;
  logic [7:0]                                  rx_frame_type;
  logic                                        rx_crc_ok;
  logic [NUM_HANDLERS-1:0]                     req_valid;
  logic [NUM_HANDLERS-1:0]                     req_ready;
  logic [NUM_HANDLERS-1:0]                     req_abort;
  logic [NUM_HANDLERS-1:0]                     rsp_valid;
  logic [NUM_HANDLERS-1:0]                     rsp_ready;
  logic [NUM_HANDLERS-1:0][7:0]                rsp_len;
  logic [NUM_HANDLERS-1:0][MAX_PAYLOAD-1:0][7:0] rsp_payload;
  logic                                        tx_frame_valid;
  logic                                        tx_frame_ready;
  logic [7:0]                                  tx_frame_len;
  logic [7:0]                                  tx_frame_type;
  logic [MAX_PAYLOAD-1:0][7:0]                 tx_frame_payload;

  modport master (
    input  rx_frame_valid, rx_frame_len, rx_frame_type, rx_crc_ok,
    output rx_frame_ready,
    output req_valid, req_abort, rsp_ready,
    input  req_ready, rsp_valid, rsp_len, rsp_payload,
    output tx_frame_valid, tx_frame_len, tx_frame_type, tx_frame_payload,
    input  tx_frame_ready
  );

  modport slave (
    output rx_frame_valid, rx_frame_len, rx_frame_type, rx_crc_ok,
    input  rx_frame_ready,
    input  req_valid, req_abort, rsp_ready,
    output req_ready, rsp_valid, rsp_len, rsp_payload,
    input  tx_frame_valid, tx_frame_len, tx_frame_type, tx_frame_payload,
    output tx_frame_ready
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Command controller: classifies each received frame, dispatches it to a handler,
// waits (bounded) for the response and emits exactly one reply frame per request.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD    = 255,
  parameter int unsigned NUM_HANDLERS   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  NACK_TYPE      = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_frame_ctrl_if.master    bus,
  output logic [15:0]          cnt_ok,
  output logic [15:0]          cnt_nack
);

  localparam int unsigned HW = (NUM_HANDLERS > 1) ? $clog2(NUM_HANDLERS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  state_t                   state_q, state_d;
  logic [HW-1:0]            h_q, h_d;
  logic [7:0]               type_q, type_d;
  logic [7:0]               code_q, code_d;
  logic [7:0]               len_q, len_d;
  logic [7:0]               txtype_q, txtype_d;
  logic                     sel_rsp_q, sel_rsp_d;
  logic                     tx_valid_q, tx_valid_d;
  logic                     rx_ready_q, rx_ready_d;
  logic [NUM_HANDLERS-1:0]  req_valid_q, req_valid_d;
  logic [NUM_HANDLERS-1:0]  req_abort_q, req_abort_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [15:0]              cnt_ok_q, cnt_ok_d;
  logic [15:0]              cnt_nack_q, cnt_nack_d;
  logic [NUM_HANDLERS-1:0]  h_onehot;
  logic [MAX_PAYLOAD-1:0][7:0] payload_mux;

  assign h_onehot = (NUM_HANDLERS)'(1) << h_q;

  always_comb begin
    logic       do_nack;
    logic [7:0] nack_code;
    do_nack     = 1'b0;
    nack_code   = '0;
    state_d     = state_q;
    h_d         = h_q;
    type_d      = type_q;
    code_d      = code_q;
    len_d       = len_q;
    txtype_d    = txtype_q;
    sel_rsp_d   = sel_rsp_q;
    tx_valid_d  = tx_valid_q;
    rx_ready_d  = 1'b0;
    req_valid_d = req_valid_q;
    req_abort_d = '0;
    tmo_d       = tmo_q;
    cnt_ok_d    = cnt_ok_q;
    cnt_nack_d  = cnt_nack_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_frame_valid) begin
          type_d = bus.rx_frame_type;
          if (!bus.rx_crc_ok) begin
            do_nack   = 1'b1;
            nack_code = NACK_CRC;
          end else if (bus.rx_frame_type == 8'd0 || bus.rx_frame_type > 8'(NUM_HANDLERS)) begin
            do_nack   = 1'b1;
            nack_code = NACK_TYPE_UNK;
          end else begin
            h_d         = HW'(bus.rx_frame_type - 8'd1);
            req_valid_d = (NUM_HANDLERS)'(1) << h_d;
            state_d     = ST_DISPATCH;
          end
        end
      end
      ST_DISPATCH: begin
        if (bus.req_ready[h_q]) begin
          req_valid_d = '0;
          tmo_d       = '0;
          state_d     = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        // A response in the final counted cycle takes priority over the abort.
        if (bus.rsp_valid[h_q]) begin
          len_d      = bus.rsp_len[h_q];
          txtype_d   = type_q | RSP_TYPE_BIT;
          sel_rsp_d  = 1'b1;
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          req_abort_d = h_onehot;
          do_nack     = 1'b1;
          nack_code   = NACK_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (bus.tx_frame_ready) begin
          tx_valid_d = 1'b0;
          rx_ready_d = 1'b1;
          state_d    = ST_RELEASE;
          if (sel_rsp_q) cnt_ok_d   = (cnt_ok_q == '1)   ? cnt_ok_q   : cnt_ok_q + 16'd1;
          else           cnt_nack_d = (cnt_nack_q == '1) ? cnt_nack_q : cnt_nack_q + 16'd1;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (do_nack) begin
      code_d     = nack_code;
      len_d      = 8'd2;
      txtype_d   = NACK_TYPE;
      sel_rsp_d  = 1'b0;
      tx_valid_d = 1'b1;
      state_d    = ST_SEND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      h_q         <= '0;
      type_q      <= '0;
      code_q      <= '0;
      len_q       <= '0;
      txtype_q    <= '0;
      sel_rsp_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
      rx_ready_q  <= 1'b0;
      req_valid_q <= '0;
      req_abort_q <= '0;
      tmo_q       <= '0;
      cnt_ok_q    <= '0;
      cnt_nack_q  <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      type_q      <= type_d;
      code_q      <= code_d;
      len_q       <= len_d;
      txtype_q    <= txtype_d;
      sel_rsp_q   <= sel_rsp_d;
      tx_valid_q  <= tx_valid_d;
      rx_ready_q  <= rx_ready_d;
      req_valid_q <= req_valid_d;
      req_abort_q <= req_abort_d;
      tmo_q       <= tmo_d;
      cnt_ok_q    <= cnt_ok_d;
      cnt_nack_q  <= cnt_nack_d;
    end
  end

  // NACK payload is {code, original TYPE, zeros}; reset selects NACK with code 0.
  always_comb begin
    payload_mux = '0;
    if (sel_rsp_q) begin
      payload_mux = bus.rsp_payload[h_q];
    end else begin
      payload_mux[0] = code_q;
      payload_mux[1] = type_q;
    end
  end

  assign bus.rx_frame_ready   = rx_ready_q;
  assign bus.req_valid        = req_valid_q;
  assign bus.req_abort        = req_abort_q;
  assign bus.rsp_ready        = (state_q == ST_SEND && sel_rsp_q && bus.tx_frame_ready) ? h_onehot : '0;
  assign bus.tx_frame_valid   = tx_valid_q;
  assign bus.tx_frame_len     = len_q;
  assign bus.tx_frame_type    = txtype_q;
  assign bus.tx_frame_payload = payload_mux;
  assign cnt_ok               = cnt_ok_q;
  assign cnt_nack             = cnt_nack_q;

endmodule
